// File: rtl/serial_add_sequencer.sv
// Bit-serial operand sequencer feeding an external combinational full adder.
// Shifts operands out LSB first and gathers sum bits into a registered result.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             busy,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_sum,
   input  logic             fa_carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry_q;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] res_q;
   logic             cout_q;

   // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   always_comb begin
      sum_nxt = sum_sh >> 1;
      sum_nxt[WIDTH-1] = fa_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         bit_cnt <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a_in;
                  b_sh    <= b_in;
                  carry_q <= cin;
                  bit_cnt <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_sh  <= sum_nxt;
               carry_q <= fa_carry;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST) begin
                  res_q  <= sum_nxt;
                  cout_q <= fa_carry;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A separate result register keeps sum_out stable after DONE is left.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign sum_out   = res_q;
   assign cout_out  = cout_q;
   assign fa_a      = (state == RUN) & a_sh[0];
   assign fa_b      = (state == RUN) & b_sh[0];
   assign fa_c      = (state == RUN) & carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a behavioural full adder.
// Uses a WIDTH=8 instance plus a WIDTH=1 instance for the exhaustive case.
module tb_serial_add_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum_out;
   logic       cout_out;
   logic       busy;
   logic       fa_a, fa_b, fa_c, fa_sum, fa_carry;

   logic       in_valid1 = 1'b0;
   logic       in_ready1;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       c1 = 1'b0;
   logic       out_valid1;
   logic       out_ready1 = 1'b1;
   logic [0:0] sum1;
   logic       cout1;
   logic       busy1;
   logic       fa_a1, fa_b1, fa_c1, fa_sum1, fa_carry1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign fa_sum    = fa_a ^ fa_b ^ fa_c;
   assign fa_carry  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
   assign fa_sum1   = fa_a1 ^ fa_b1 ^ fa_c1;
   assign fa_carry1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

   serial_add_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .cout_out(cout_out), .busy(busy),
      .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
      .fa_sum(fa_sum), .fa_carry(fa_carry)
   );

   serial_add_sequencer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a_in(a1), .b_in(b1), .cin(c1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum_out(sum1), .cout_out(cout1), .busy(busy1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1),
      .fa_sum(fa_sum1), .fa_carry(fa_carry1)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] b,
                        input logic c);
      a_in = a;
      b_in = b;
      cin = c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      int         prev;
      logic [1:0] exp1;

      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout_out, 0);
      chk("rst_fa", {fa_a, fa_b, fa_c}, 0);
      step();
      rst_n = 1'b1;
      step();

      // 0x5A + 0x3C
      a = 8'h5A;
      start(a, 8'h3C, 1'b0);
      chk("t1_in_ready", in_ready, 0);
      chk("t1_busy", busy, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_fa_a%0d", i), fa_a, a[i]);
         chk($sformatf("t1_nov%0d", i), out_valid, 0);
         step();
      end
      chk("t1_out_valid", out_valid, 1);
      chk("t1_sum", sum_out, 8'h96);
      chk("t1_cout", cout_out, 0);
      chk("t1_done_fa", {fa_a, fa_b, fa_c}, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1_idle_ready", in_ready, 1);
      chk("t1_idle_ov", out_valid, 0);
      chk("t1_sum_held", sum_out, 8'h96);

      // 0xFF + 0x01: carry ripples through every bit
      start(8'hFF, 8'h01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_fa_c%0d", i), fa_c, (i == 0) ? 0 : 1);
         step();
      end
      chk("t2_sum", sum_out, 8'h00);
      chk("t2_cout", cout_out, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // 0xFF + 0xFF + 1 with backpressure
      start(8'hFF, 8'hFF, 1'b1);
      repeat (8) step();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_ov%0d", i), out_valid, 1);
         chk($sformatf("t3_sum%0d", i), sum_out, 8'hFF);
         chk($sformatf("t3_cout%0d", i), cout_out, 1);
         chk($sformatf("t3_rdy%0d", i), in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_idle", in_ready, 1);
      chk("t3_ov_low", out_valid, 0);

      // in_valid during RUN must be ignored
      start(8'h01, 8'h02, 1'b0);
      repeat (3) step();
      a_in = 8'h11;
      b_in = 8'h22;
      in_valid = 1'b1;
      chk("t4_rdy_run", in_ready, 0);
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("t4_ov", out_valid, 1);
      chk("t4_sum", sum_out, 8'h03);
      chk("t4_cout", cout_out, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t4_idle", in_ready, 1);

      // asynchronous reset mid-RUN
      start(8'hA5, 8'h5A, 1'b1);
      repeat (4) step();
      chk("t5_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_ov", out_valid, 0);
      chk("t5_rdy", in_ready, 1);
      chk("t5_busy", busy, 0);
      chk("t5_sum", sum_out, 0);
      chk("t5_fa", {fa_a, fa_b, fa_c}, 0);
      step();
      rst_n = 1'b1;
      step();
      start(8'h80, 8'h80, 1'b0);
      repeat (8) step();
      chk("t5_ov2", out_valid, 1);
      chk("t5_sum2", sum_out, 8'h00);
      chk("t5_cout2", cout_out, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // WIDTH=1 exhaustive, valid and ready tied high
      prev = 0;
      in_valid1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a1 = 1'(k >> 2);
         b1 = 1'(k >> 1);
         c1 = 1'(k);
         exp1 = 2'(a1) + 2'(b1) + 2'(c1);
         chk($sformatf("w1_rdy%0d", k), in_ready1, 1);
         step();
         if (k > 0) chk($sformatf("w1_gap%0d", k), cyc - prev, 3);
         prev = cyc;
         chk($sformatf("w1_run%0d", k), out_valid1, 0);
         step();
         chk($sformatf("w1_ov%0d", k), out_valid1, 1);
         chk($sformatf("w1_res%0d", k), {cout1, sum1}, exp1);
         step();
      end
      in_valid1 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial operand sequencer that sits directly upstream of the team's combinational full-adder cell.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Presents one bit pair per cycle, LSB first, on the full-adder inputs, and registers the returned carry back into the adder on the next cycle.
- Collects the returned sum bits into a WIDTH-bit result, presented on a valid/ready output handshake.

Parameters:
WIDTH  8  operand/result width in bits; legal range 1..64

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
sum_out  output  WIDTH  result sum
cout_out  output  1  final carry-out
busy  output  1  high in RUN or DONE
fa_a  output  1  to full-adder input a
fa_b  output  1  to full-adder input b
fa_c  output  1  to full-adder input c (carry-in)
fa_sum  input  1  from full-adder sum
fa_carry  input  1  from full-adder carry

Behaviour:
Reset (rst_n low, asynchronous, any state):
- state=IDLE; all internal registers cleared (a_sh, b_sh, sum_sh, carry_q, bit_cnt).
- in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0, fa_a=fa_b=fa_c=0.
- A reset during RUN or DONE aborts the operation and discards the result; no partial output.

IDLE:
- in_ready=1.
- On a clk edge with in_valid=1: a_sh<=a_in, b_sh<=b_in, carry_q<=cin, bit_cnt<=0, state<=RUN.
- in_valid=0: remain in IDLE.

RUN:
- in_ready=0; in_valid is ignored and the operands are not latched.
- Combinational drive: fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_q.
- Each edge:
  - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}
  - carry_q<=fa_carry
  - a_sh, b_sh shift right by 1, zero-filling the MSB
  - bit_cnt++
- When bit_cnt==WIDTH-1 on an edge, that edge performs the last shift and sets state<=DONE.
- Exactly WIDTH RUN cycles.
- bit_cnt width is max(1,$clog2(WIDTH)); it must not wrap before the exit condition.

DONE:
- out_valid=1; sum_out=sum_sh and cout_out=carry_q, both registered and stable while out_valid=1.
- fa_a/fa_b/fa_c=0.
- On an edge with out_ready=1: state<=IDLE, out_valid falls.
- out_ready=0: hold indefinitely with the result unchanged (backpressure).
- sum_out/cout_out keep their last value after leaving DONE until the next result.

Timing and handshake rules:
- Latency: operand handshake at edge N -> out_valid=1 after edge N+WIDTH.
- Throughput: one operation per WIDTH+2 cycles. in_ready returns 1 the cycle after the output handshake; no same-cycle accept in DONE.
- out_ready while out_valid=0 has no effect.
- A handshake occurs only when valid and ready are both high at the clock edge.
- WIDTH=1: a single RUN cycle, with the same rules.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout_out.
- The full-adder path is purely combinational (fa_* out -> fa_sum/fa_carry in, same cycle). The block must not register fa_sum/fa_carry anywhere except sum_sh and carry_q.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> out_valid 8 cycles after accept, sum_out=0x96, cout_out=0. fa_a sequence LSB-first is 0,1,0,1,1,0,1,0.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout_out=1. fa_c=1 on RUN cycles 1..7, 0 on cycle 0.
- a=0xFF, b=0xFF, cin=1 -> sum_out=0xFF, cout_out=1. Hold out_ready=0 for 5 cycles: out_valid, sum_out and cout_out stable; in_ready=0 throughout; release -> IDLE next cycle.
- Assert in_valid with a=0x11, b=0x22 on RUN cycle 3 of an ongoing 0x01+0x02 -> ignored; result=0x03, cout=0.
- Pulse rst_n low at RUN cycle 4 -> immediately out_valid=0, in_ready=1, sum_out=0, fa_*=0. Next op 0x80+0x80 cin=0 -> sum_out=0x00, cout_out=1.
- Back-to-back with out_ready tied 1 and in_valid tied 1, WIDTH=1, exhaustive a,b,cin -> 8 results match a+b+cin. Accepts are spaced 3 cycles apart.
